ps2_key_sender: RTL and testbench
=================================

// Module: ps2_key_sender
// PURPOSE
//  Device-side PS/2 keyboard emulator: accepts one ASCII character per valid/ready
//  handshake and maps it to its set-2 scan code. Emits one keystroke on ps2_clk/ps2_data
//  as three frames: make code, 0xF0, make code (press then release).
//  Feeds the keyboard receiver/decoder path; the scan code to ASCII table is its exact inverse.
// PARAMETERS
//  CLK_DIV    4   system clocks per PS/2 clock half-period (>=2)
//  GAP_CYCLES 16  idle clocks, both lines high, after every frame (>=1)
// PORTS
//  clk       in   1  system clock, all logic on rising edge
//  rst       in   1  synchronous reset, active-high
//  ascii     in   8  character to send, sampled only on accept
//  valid     in   1  request; accept = valid && ready
//  ready     out  1  high only in IDLE
//  busy      out  1  high from cycle after accept until final gap ends
//  err       out  1  one-cycle pulse: accepted ascii has no scan code, nothing sent
//  ps2_clk   out  1  PS/2 clock, idle high
//  ps2_data  out  1  PS/2 data, idle high
// BEHAVIOUR
//  - Reset (any state, mid-frame included): next cycle ps2_clk=1, ps2_data=1, ready=1,
//    busy=0, err=0. FSM goes to IDLE; partial frame abandoned, no stop bit appended.
//  - Map (combinational, inverse of decoder table):
//    digits 0-9 -> 45,16,1E,26,25,2E,36,3D,3E,46
//    a-z -> 1C,32,21,23,24,2B,34,33,43,3B,42,4B,3A,31,44,4D,15,2D,1B,2C,3C,2A,1D,22,35,1A
//    ' '->29  '-'->4E  '='->55  '['->54  ']'->5B  '\'->5D  ';'->4C  '''->52
//    ','->41  '.'->49  '/'->4A  '`'->0E. Any other code (uppercase, 0xFF, controls) unsupported.
//  - Accept cycle: latch scan code. If unsupported: err=1 next cycle, stay IDLE,
//    ready stays 1. Else ready=0, busy=1 next cycle.
//  - FSM: IDLE -> FRAME(idx0=make) -> GAP -> FRAME(idx1=F0) -> GAP -> FRAME(idx2=make) -> GAP -> IDLE.
//  - Frame = 11 bits: start 0, data[0..7] LSB first, odd parity (~^data), stop 1.
//    Each bit is 2*CLK_DIV cycles: first CLK_DIV with ps2_clk=1 and ps2_data=bit,
//    then CLK_DIV with ps2_clk=0 (data stable across falling edge).
//  - Frame length 22*CLK_DIV cycles; GAP holds both lines high GAP_CYCLES cycles.
//  - Latency: first start bit on ps2_data 1 cycle after accept. Ready returns
//    3*(22*CLK_DIV+GAP_CYCLES) cycles after accept (312 at defaults).
//  - valid while busy ignored; ascii changes after accept have no effect.
//  - Back-to-back: valid held high re-accepts in the first IDLE cycle; no extra gap.
//  - Outputs registered, glitch-free; counters saturate-free (wrap exactly at terminal count).
// STRUCTURE
//  - ps2_pkg: PS2_BREAK=8'hF0, PS2_FRAME_BITS=11, FSM state enum,
//    function ascii_to_scan(ascii)->{ok,code}.
//  - Sub-module ps2_frame_tx: byte serializer, start/byte_in -> done pulse, owns
//    half-period counter, bit index, parity. Top sequences three frames and gaps.
// TESTING
//  - Reset -> ps2_clk=1, ps2_data=1, ready=1, busy=0, err=0.
//  - Send 'a' (0x61) -> frames 1C (parity 0), F0 (parity 1), 1C. Falling-edge sampler
//    decodes 1C,F0,1C; ready back after 312 cycles.
//  - Send '1' (0x31) -> make 0x16, parity 0; decoder loopback returns ascii 0x31.
//  - Send 'A' (0x41) -> err pulse 1 cycle, lines stay high, ready stays 1.
//  - Assert rst at bit 5 of F0 frame -> lines high next cycle; IDLE; next 'z' sends 1A,F0,1A cleanly.
//  - valid held for 'q','w' -> 15,F0,15,1D,F0,1D; valid ignored while busy; gaps each 16 cycles.
//    Sweep all 48 supported characters through a loopback decoder; each must round-trip.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared constants, FSM state type and the ASCII -> PS/2 set-2 scan code map.
//   PS2_BREAK      : break prefix byte sent between make codes
//   PS2_FRAME_BITS : start + 8 data + parity + stop
//   ascii_to_scan  : {ok, code}; ok=0 for characters without a scan code
package ps2_pkg;

    localparam logic [7:0]  PS2_BREAK      = 8'hF0;
    localparam int unsigned PS2_FRAME_BITS = 11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FRAME,
        ST_GAP
    } ps2_state_e;

    typedef struct packed {
        logic       ok;
        logic [7:0] code;
    } scan_t;

    // Exact inverse of the receiver's scan code -> ASCII table.
    function automatic scan_t ascii_to_scan(input logic [7:0] ascii);
        scan_t r;
        r.ok   = 1'b1;
        r.code = 8'h00;
        case (ascii)
            8'h30: r.code = 8'h45;  8'h31: r.code = 8'h16;  8'h32: r.code = 8'h1E;  8'h33: r.code = 8'h26;
            8'h34: r.code = 8'h25;  8'h35: r.code = 8'h2E;  8'h36: r.code = 8'h36;  8'h37: r.code = 8'h3D;
            8'h38: r.code = 8'h3E;  8'h39: r.code = 8'h46;
            8'h61: r.code = 8'h1C;  8'h62: r.code = 8'h32;  8'h63: r.code = 8'h21;  8'h64: r.code = 8'h23;
            8'h65: r.code = 8'h24;  8'h66: r.code = 8'h2B;  8'h67: r.code = 8'h34;  8'h68: r.code = 8'h33;
            8'h69: r.code = 8'h43;  8'h6A: r.code = 8'h3B;  8'h6B: r.code = 8'h42;  8'h6C: r.code = 8'h4B;
            8'h6D: r.code = 8'h3A;  8'h6E: r.code = 8'h31;  8'h6F: r.code = 8'h44;  8'h70: r.code = 8'h4D;
            8'h71: r.code = 8'h15;  8'h72: r.code = 8'h2D;  8'h73: r.code = 8'h1B;  8'h74: r.code = 8'h2C;
            8'h75: r.code = 8'h3C;  8'h76: r.code = 8'h2A;  8'h77: r.code = 8'h1D;  8'h78: r.code = 8'h22;
            8'h79: r.code = 8'h35;  8'h7A: r.code = 8'h1A;
            8'h20: r.code = 8'h29;  8'h2D: r.code = 8'h4E;  8'h3D: r.code = 8'h55;  8'h5B: r.code = 8'h54;
            8'h5D: r.code = 8'h5B;  8'h5C: r.code = 8'h5D;  8'h3B: r.code = 8'h4C;  8'h27: r.code = 8'h52;
            8'h2C: r.code = 8'h41;  8'h2E: r.code = 8'h49;  8'h2F: r.code = 8'h4A;  8'h60: r.code = 8'h0E;
            default: r.ok = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/ps2_key_sender_frame_tx.sv
// Single PS/2 frame serializer: start bit, 8 data bits LSB first, odd parity, stop.
//   clk, rst  : system clock, synchronous active-high reset
//   start     : load byte_in and begin a frame (ignored while a frame is active)
//   byte_in   : byte to serialize
//   ps2_clk   : registered PS/2 clock, idle high
//   ps2_data  : registered PS/2 data, idle high
//   done_c    : high in the last cycle of the stop bit's low half
module ps2_frame_tx
    import ps2_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] byte_in,
    output logic       ps2_clk,
    output logic       ps2_data,
    output logic       done_c
);

    localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned BW = $clog2(PS2_FRAME_BITS);
    localparam int unsigned SW = PS2_FRAME_BITS - 1;

    logic          active;
    logic          low_phase;
    logic [CW-1:0] half_cnt;
    logic [BW-1:0] bit_idx;
    logic [SW-1:0] bits_q;   // bits still to send after the start bit: {stop, parity, data}
    logic          half_end;

    assign half_end = (half_cnt == CW'(CLK_DIV - 1));
    assign done_c   = active && low_phase && half_end && (bit_idx == BW'(PS2_FRAME_BITS - 1));

    // Each bit: CLK_DIV cycles clock high with data set up, then CLK_DIV cycles clock low.
    always_ff @(posedge clk) begin
        if (rst) begin
            active    <= 1'b0;
            low_phase <= 1'b0;
            half_cnt  <= '0;
            bit_idx   <= '0;
            bits_q    <= '1;
            ps2_clk   <= 1'b1;
            ps2_data  <= 1'b1;
        end else if (start && !active) begin
            active    <= 1'b1;
            low_phase <= 1'b0;
            half_cnt  <= '0;
            bit_idx   <= '0;
            bits_q    <= {1'b1, ~^byte_in, byte_in};
            ps2_clk   <= 1'b1;
            ps2_data  <= 1'b0;
        end else if (active) begin
            if (half_end) begin
                half_cnt <= '0;
                if (!low_phase) begin
                    low_phase <= 1'b1;
                    ps2_clk   <= 1'b0;
                end else if (bit_idx == BW'(PS2_FRAME_BITS - 1)) begin
                    active    <= 1'b0;
                    low_phase <= 1'b0;
                    ps2_clk   <= 1'b1;
                    ps2_data  <= 1'b1;
                end else begin
                    low_phase <= 1'b0;
                    bit_idx   <= bit_idx + BW'(1);
                    ps2_clk   <= 1'b1;
                    ps2_data  <= bits_q[0];
                    bits_q    <= {1'b1, bits_q[SW-1:1]};
                end
            end else begin
                half_cnt <= half_cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/ps2_key_sender.sv
// PS/2 keyboard emulator: one ASCII character per valid/ready handshake becomes
// make, F0, make frames, each followed by an idle gap.
//   clk, rst  : system clock, synchronous active-high reset
//   ascii     : character, sampled on accept (valid && ready)
//   valid     : request
//   ready     : high only in IDLE
//   busy      : high from the cycle after accept until the final gap ends
//   err       : one-cycle pulse when the accepted character has no scan code
//   ps2_clk   : PS/2 clock, idle high
//   ps2_data  : PS/2 data, idle high
module ps2_key_sender
    import ps2_pkg::*;
#(
    parameter int unsigned CLK_DIV    = 4,
    parameter int unsigned GAP_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] ascii,
    input  logic       valid,
    output logic       ready,
    output logic       busy,
    output logic       err,
    output logic       ps2_clk,
    output logic       ps2_data
);

    localparam int unsigned GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    // The IDLE cycle that raises ready is itself the last idle-line cycle of the final gap.
    localparam int unsigned GAP_LAST_MID = GAP_CYCLES - 1;
    localparam int unsigned GAP_LAST_END = (GAP_CYCLES > 1) ? GAP_CYCLES - 2 : 0;

    ps2_state_e    state;
    logic [1:0]    frame_idx;
    logic [GW-1:0] gap_cnt;
    logic [7:0]    scan_q;

    scan_t         lookup_c;
    logic          gap_last_c;
    logic          tx_start_c;
    logic [7:0]    tx_byte_c;
    logic          tx_done_c;

    // Frame start and byte selection: first frame straight from the lookup, later ones from the latch.
    always_comb begin
        lookup_c   = ascii_to_scan(ascii);
        gap_last_c = (frame_idx == 2'd2) ? (gap_cnt == GW'(GAP_LAST_END))
                                         : (gap_cnt == GW'(GAP_LAST_MID));
        tx_start_c = 1'b0;
        tx_byte_c  = scan_q;
        if (state == ST_IDLE && valid && lookup_c.ok) begin
            tx_start_c = 1'b1;
            tx_byte_c  = lookup_c.code;
        end else if (state == ST_GAP && gap_last_c && frame_idx != 2'd2) begin
            tx_start_c = 1'b1;
            tx_byte_c  = (frame_idx == 2'd0) ? PS2_BREAK : scan_q;
        end
    end

    // Keystroke sequencer: three frames separated by gaps.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            frame_idx <= 2'd0;
            gap_cnt   <= '0;
            scan_q    <= 8'h00;
            ready     <= 1'b1;
            busy      <= 1'b0;
            err       <= 1'b0;
        end else begin
            err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (valid) begin
                        if (lookup_c.ok) begin
                            scan_q    <= lookup_c.code;
                            frame_idx <= 2'd0;
                            state     <= ST_FRAME;
                            ready     <= 1'b0;
                            busy      <= 1'b1;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                ST_FRAME: begin
                    if (tx_done_c) begin
                        gap_cnt <= '0;
                        if (frame_idx == 2'd2 && GAP_CYCLES == 1) begin
                            state <= ST_IDLE;
                            ready <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            state <= ST_GAP;
                        end
                    end
                end
                ST_GAP: begin
                    if (gap_last_c) begin
                        gap_cnt <= '0;
                        if (frame_idx == 2'd2) begin
                            state <= ST_IDLE;
                            ready <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            state     <= ST_FRAME;
                            frame_idx <= frame_idx + 2'd1;
                        end
                    end else begin
                        gap_cnt <= gap_cnt + GW'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    ps2_frame_tx #(
        .CLK_DIV (CLK_DIV)
    ) u_frame_tx (
        .clk      (clk),
        .rst      (rst),
        .start    (tx_start_c),
        .byte_in  (tx_byte_c),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .done_c   (tx_done_c)
    );

endmodule

// File: tb/tb_ps2_key_sender.sv
// Directed bench for ps2_key_sender with a falling-edge PS/2 frame sampler and
// a scan code -> ASCII loopback decoder.
module tb_ps2_key_sender;

    logic       clk;
    logic       rst;
    logic [7:0] ascii;
    logic       valid;
    logic       ready;
    logic       busy;
    logic       err;
    logic       ps2_clk;
    logic       ps2_data;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] tbl_ascii [48] = '{
        8'h30, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
        8'h61, 8'h62, 8'h63, 8'h64, 8'h65, 8'h66, 8'h67, 8'h68, 8'h69, 8'h6A,
        8'h6B, 8'h6C, 8'h6D, 8'h6E, 8'h6F, 8'h70, 8'h71, 8'h72, 8'h73, 8'h74,
        8'h75, 8'h76, 8'h77, 8'h78, 8'h79, 8'h7A,
        8'h20, 8'h2D, 8'h3D, 8'h5B, 8'h5D, 8'h5C, 8'h3B, 8'h27, 8'h2C, 8'h2E, 8'h2F, 8'h60};
    logic [7:0] tbl_scan [48] = '{
        8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46,
        8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43, 8'h3B,
        8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C,
        8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A,
        8'h29, 8'h4E, 8'h55, 8'h54, 8'h5B, 8'h5D, 8'h4C, 8'h52, 8'h41, 8'h49, 8'h4A, 8'h0E};

    // Frame sampler state, written only by the sampler process.
    logic [10:0] rx_sh;
    int          rx_cnt  = 0;
    int          rx_n    = 0;
    int          rx_bad  = 0;
    int          cyc     = 0;
    logic        prev_clk = 1'b1;
    logic [7:0]  rx_log [512];
    logic        rx_par [512];
    int          rx_end [512];

    ps2_key_sender #(
        .CLK_DIV    (4),
        .GAP_CYCLES (16)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .ascii    (ascii),
        .valid    (valid),
        .ready    (ready),
        .busy     (busy),
        .err      (err),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Host-side receiver: samples data on each ps2_clk falling edge, sampled mid-cycle.
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (rst) begin
            rx_cnt   = 0;
            prev_clk = 1'b1;
        end else begin
            if (prev_clk && !ps2_clk) begin
                rx_sh[rx_cnt] = ps2_data;
                rx_cnt = rx_cnt + 1;
                if (rx_cnt == 11) begin
                    if (rx_sh[0] !== 1'b0 || rx_sh[10] !== 1'b1 || rx_sh[9] !== ~^rx_sh[8:1])
                        rx_bad = rx_bad + 1;
                    if (rx_n < 512) begin
                        rx_log[rx_n] = rx_sh[8:1];
                        rx_par[rx_n] = rx_sh[9];
                        rx_end[rx_n] = cyc;
                        rx_n = rx_n + 1;
                    end
                    rx_cnt = 0;
                end
            end
            prev_clk = ps2_clk;
        end
    end

    function automatic logic [7:0] scan_to_ascii(input logic [7:0] code);
        logic [7:0] r;
        r = 8'h00;
        for (int i = 0; i < 48; i++)
            if (tbl_scan[i] == code) r = tbl_ascii[i];
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits for ready, then presents c for exactly one accept edge; returns in cycle 1 after accept.
    task automatic start_char(input logic [7:0] c);
        int k;
        k = 0;
        while (!ready && k < 2000) begin
            tick();
            k++;
        end
        if (!ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL start_wait: ready=%0b after %0d cycles, required 1", ready, k);
        end
        ascii = c;
        valid = 1'b1;
        tick();
        valid = 1'b0;
    endtask

    // Counts cycles since accept until ready returns (called in cycle 1).
    task automatic wait_ready(output int n);
        n = 1;
        while (!ready && n < 2000) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        valid = 1'b0;
        ascii = 8'h00;
        repeat (3) tick();
        n_tests++; if (ps2_clk !== 1'b1)  begin n_fail++; $display("FAIL reset_ps2_clk: got %b want 1", ps2_clk); end
        n_tests++; if (ps2_data !== 1'b1) begin n_fail++; $display("FAIL reset_ps2_data: got %b want 1", ps2_data); end
        n_tests++; if (ready !== 1'b1)    begin n_fail++; $display("FAIL reset_ready: got %b want 1", ready); end
        n_tests++; if (busy !== 1'b0)     begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_tests++; if (err !== 1'b0)      begin n_fail++; $display("FAIL reset_err: got %b want 0", err); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_send_a();
        int base, n;
        base = rx_n;
        start_char(8'h61);
        n_tests++; if (ps2_data !== 1'b0 || ps2_clk !== 1'b1)
            begin n_fail++; $display("FAIL a_start_bit: clk=%b data=%b want clk=1 data=0", ps2_clk, ps2_data); end
        n_tests++; if (busy !== 1'b1 || ready !== 1'b0)
            begin n_fail++; $display("FAIL a_busy: busy=%b ready=%b want 1/0", busy, ready); end
        wait_ready(n);
        n_tests++; if (n !== 312) begin n_fail++; $display("FAIL a_latency: got %0d want 312", n); end
        n_tests++; if (rx_n - base !== 3) begin n_fail++; $display("FAIL a_frames: got %0d want 3", rx_n - base); end
        n_tests++; if (rx_log[base] !== 8'h1C || rx_log[base+1] !== 8'hF0 || rx_log[base+2] !== 8'h1C)
            begin n_fail++; $display("FAIL a_bytes: got %h %h %h want 1c f0 1c", rx_log[base], rx_log[base+1], rx_log[base+2]); end
        n_tests++; if (rx_par[base] !== 1'b0 || rx_par[base+1] !== 1'b1)
            begin n_fail++; $display("FAIL a_parity: got %b %b want 0 1", rx_par[base], rx_par[base+1]); end
        n_tests++; if (rx_bad !== 0) begin n_fail++; $display("FAIL a_framing: got %0d bad frames want 0", rx_bad); end
    endtask

    task automatic test_send_1();
        int base, n;
        base = rx_n;
        start_char(8'h31);
        wait_ready(n);
        n_tests++; if (rx_log[base] !== 8'h16 || rx_par[base] !== 1'b0)
            begin n_fail++; $display("FAIL one_make: got %h par %b want 16 par 0", rx_log[base], rx_par[base]); end
        n_tests++; if (scan_to_ascii(rx_log[base+2]) !== 8'h31)
            begin n_fail++; $display("FAIL one_loopback: got %h want 31", scan_to_ascii(rx_log[base+2])); end
    endtask

    task automatic test_unsupported();
        int base;
        logic line_low;
        base = rx_n;
        ascii = 8'h41;
        valid = 1'b1;
        tick();
        valid = 1'b0;
        n_tests++; if (err !== 1'b1)   begin n_fail++; $display("FAIL bad_err_pulse: got %b want 1", err); end
        n_tests++; if (ready !== 1'b1 || busy !== 1'b0)
            begin n_fail++; $display("FAIL bad_ready: ready=%b busy=%b want 1/0", ready, busy); end
        tick();
        n_tests++; if (err !== 1'b0)   begin n_fail++; $display("FAIL bad_err_width: got %b want 0", err); end
        line_low = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (ps2_clk !== 1'b1 || ps2_data !== 1'b1) line_low = 1'b1;
            tick();
        end
        n_tests++; if (line_low !== 1'b0 || rx_n !== base)
            begin n_fail++; $display("FAIL bad_lines_idle: low=%b frames=%0d want 0/0", line_low, rx_n - base); end
    endtask

    task automatic test_reset_mid();
        int base, bad0, n;
        base = rx_n;
        bad0 = rx_bad;
        start_char(8'h7A);
        repeat (148) tick();  // cycle 149: low half of bit 5 of the F0 frame
        n_tests++; if (ps2_clk !== 1'b0 || ps2_data !== 1'b1)
            begin n_fail++; $display("FAIL mid_bit5: clk=%b data=%b want 0/1", ps2_clk, ps2_data); end
        rst = 1'b1;
        tick();
        n_tests++; if (ps2_clk !== 1'b1 || ps2_data !== 1'b1)
            begin n_fail++; $display("FAIL mid_rst_lines: clk=%b data=%b want 1/1", ps2_clk, ps2_data); end
        n_tests++; if (ready !== 1'b1 || busy !== 1'b0 || err !== 1'b0)
            begin n_fail++; $display("FAIL mid_rst_state: ready=%b busy=%b err=%b want 1/0/0", ready, busy, err); end
        rst = 1'b0;
        tick();
        n_tests++; if (rx_n - base !== 1 || rx_log[base] !== 8'h1A)
            begin n_fail++; $display("FAIL mid_partial: frames=%0d first=%h want 1/1a", rx_n - base, rx_log[base]); end
        base = rx_n;
        start_char(8'h7A);
        wait_ready(n);
        n_tests++; if (rx_n - base !== 3 || rx_log[base] !== 8'h1A || rx_log[base+1] !== 8'hF0 || rx_log[base+2] !== 8'h1A)
            begin n_fail++; $display("FAIL mid_resend: n=%0d got %h %h %h want 1a f0 1a", rx_n - base, rx_log[base], rx_log[base+1], rx_log[base+2]); end
        n_tests++; if (rx_bad !== bad0 || n !== 312)
            begin n_fail++; $display("FAIL mid_resend_clean: bad=%0d lat=%0d want %0d/312", rx_bad, n, bad0); end
    endtask

    task automatic test_back_to_back();
        int base, n;
        logic [7:0] exp_b [6];
        exp_b = '{8'h15, 8'hF0, 8'h15, 8'h1D, 8'hF0, 8'h1D};
        base = rx_n;
        start_char(8'h71);
        valid = 1'b1;       // held through busy; must be ignored until IDLE
        ascii = 8'h77;      // change after accept must not affect 'q'
        wait_ready(n);
        n_tests++; if (n !== 312) begin n_fail++; $display("FAIL b2b_q_latency: got %0d want 312", n); end
        tick();
        valid = 1'b0;
        n_tests++; if (ready !== 1'b0 || busy !== 1'b1 || ps2_data !== 1'b0)
            begin n_fail++; $display("FAIL b2b_reaccept: ready=%b busy=%b data=%b want 0/1/0", ready, busy, ps2_data); end
        wait_ready(n);
        n_tests++; if (rx_n - base !== 6) begin n_fail++; $display("FAIL b2b_frames: got %0d want 6", rx_n - base); end
        for (int i = 0; i < 6; i++) begin
            n_tests++; if (rx_log[base+i] !== exp_b[i])
                begin n_fail++; $display("FAIL b2b_byte%0d: got %h want %h", i, rx_log[base+i], exp_b[i]); end
        end
        for (int i = 1; i < 6; i++) begin
            n_tests++; if (rx_end[base+i] - rx_end[base+i-1] !== 104)
                begin n_fail++; $display("FAIL b2b_spacing%0d: got %0d want 104", i, rx_end[base+i] - rx_end[base+i-1]); end
        end
    endtask

    task automatic test_sweep();
        int base, n;
        logic [7:0] got;
        for (int i = 0; i < 48; i++) begin
            base = rx_n;
            start_char(tbl_ascii[i]);
            wait_ready(n);
            got = 8'hFF;
            if (rx_n - base == 3 && rx_log[base+1] == 8'hF0 && rx_log[base+2] == rx_log[base])
                got = scan_to_ascii(rx_log[base]);
            n_tests++; if (got !== tbl_ascii[i] || n !== 312)
                begin n_fail++; $display("FAIL sweep_%h: got %h lat %0d want %h lat 312", tbl_ascii[i], got, n, tbl_ascii[i]); end
        end
        n_tests++; if (rx_bad !== 0) begin n_fail++; $display("FAIL sweep_framing: got %0d bad frames want 0", rx_bad); end
    endtask

    initial begin
        rst   = 1'b1;
        valid = 1'b0;
        ascii = 8'h00;
        test_reset();
        test_send_a();
        test_send_1();
        test_unsupported();
        test_reset_mid();
        test_back_to_back();
        test_sweep();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
